// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: master requests/chipselect/wait-state inputs and the
// grant/strobe/ack outputs of the arbiter.
interface bus_arbiter_if #(
    parameter int unsigned NMASTER = 3,
    parameter int unsigned NCS     = 10
);
    logic [NMASTER-1:0] req;
    logic [NCS-1:0]     cs;
    logic [4*NCS-1:0]   ws_table;
    logic               ext_wait;
    logic [NMASTER-1:0] grant;
    logic               start;
    logic [NMASTER-1:0] ack;
    logic               error;
    logic               busy;

    modport master (
        output req, cs, ws_table, ext_wait,
        input  grant, start, ack, error, busy
    );

    modport slave (
        input  req, cs, ws_table, ext_wait,
        output grant, start, ack, error, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter and access sequencer: grants one master at a time, applies
// per-chipselect wait states, honors slave stalls with timeout, and returns ack/error.
module bus_arbiter #(
    parameter int unsigned NMASTER = 3,
    parameter int unsigned NCS     = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input logic           clock,
    input logic           reset,
    bus_arbiter_if.slave  bus_io
);
    localparam int unsigned IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NMASTER-1:0] grant_q, grant_d;
    logic [IW-1:0]      last_q, last_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               err_q, err_d;

    logic               arb_found;
    logic [IW-1:0]      arb_idx;
    logic [IW-1:0]      cand;
    logic [3:0]         ws_sel;

    // Search upward from last+1 with wrap; first hit wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NMASTER; i++) begin
            cand = IW'((32'(last_q) + i) % NMASTER);
            if (!arb_found && bus_io.req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Descending scan so the lowest set chipselect overrides a decoder fault.
    always_comb begin
        ws_sel = '0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if (bus_io.cs[i]) ws_sel = bus_io.ws_table[4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    grant_d = NMASTER'(1) << arb_idx;
                    last_d  = arb_idx;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!(|bus_io.cs)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wcnt_d  = ws_sel;
                    tcnt_d  = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!(|(bus_io.req & grant_q))) begin
                    grant_d = '0;
                    state_d = StIdle;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (bus_io.ext_wait && (tcnt_q == TW'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (bus_io.ext_wait) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                grant_d = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IW'(NMASTER - 1);
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    assign bus_io.grant = grant_q;
    assign bus_io.start = (state_q == StStart);
    assign bus_io.ack   = (state_q == StDone) ? grant_q : '0;
    assign bus_io.error = (state_q == StDone) && err_q;
    assign bus_io.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NMASTER=3, NCS=10, TIMEOUT=15).
module tb_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    bus_arbiter_if #(.NMASTER(3), .NCS(10)) bus ();

    bus_arbiter #(.NMASTER(3), .NCS(10), .TIMEOUT(15)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, 32'(bus.grant), 32'd0);
        check({tag, ".start"}, 32'(bus.start), 32'd0);
        check({tag, ".ack"},   32'(bus.ack),   32'd0);
        check({tag, ".error"}, 32'(bus.error), 32'd0);
        check({tag, ".busy"},  32'(bus.busy),  32'd0);
    endtask

    initial begin
        logic [2:0] exp_grant [4];
        logic [2:0] drop_mask;
        int         restore_cyc;

        bus.req      = '0;
        bus.cs       = '0;
        bus.ws_table = '0;
        bus.ext_wait = 1'b0;
        bus.ws_table[3:0] = 4'd5;  // cs0 has 5 wait states, all others 0
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");

        // 1: master 0 alone, cs6, no waits
        bus.cs  = 10'b00_0100_0000;
        bus.req = 3'b001;
        tick();
        check("t1.grant", 32'(bus.grant), 32'b001);
        check("t1.start", 32'(bus.start), 32'd1);
        check("t1.busy",  32'(bus.busy),  32'd1);
        tick();
        check("t1.ack_c2", 32'(bus.ack), 32'd0);
        tick();
        check("t1.ack",   32'(bus.ack),   32'b001);
        check("t1.error", 32'(bus.error), 32'd0);
        bus.req = '0;
        tick();
        check("t1.busy_c4", 32'(bus.busy), 32'd0);

        // 2: cs0 with 5 wait states then 2 stall cycles -> ack in cycle 10
        bus.cs  = 10'b00_0000_0001;
        bus.req = 3'b001;
        for (int c = 1; c <= 10; c++) begin
            tick();
            bus.ext_wait = (c == 7 || c == 8);
            if (c == 9)  check("t2.ack_c9", 32'(bus.ack), 32'd0);
            if (c == 10) begin
                check("t2.ack",   32'(bus.ack),   32'b001);
                check("t2.error", 32'(bus.error), 32'd0);
            end
        end
        bus.req = '0;
        tick();

        // 3: all masters requesting, from reset -> 001, 010, 100, 001
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_grant[0] = 3'b001;
        exp_grant[1] = 3'b010;
        exp_grant[2] = 3'b100;
        exp_grant[3] = 3'b001;
        bus.cs      = 10'b00_0100_0000;
        bus.req     = 3'b111;
        drop_mask   = '0;
        restore_cyc = -1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == restore_cyc) bus.req = bus.req | drop_mask;
            if ((c % 4) == 1) check("t3.grant", 32'(bus.grant), 32'(exp_grant[c/4]));
            if ((c % 4) == 3) begin
                check("t3.ack", 32'(bus.ack), 32'(exp_grant[c/4]));
                drop_mask   = exp_grant[c/4];
                bus.req     = bus.req & ~drop_mask;
                restore_cyc = c + 2;
            end
        end
        bus.req = '0;
        tick();

        // 4: unmapped access by master 1
        bus.cs  = '0;
        bus.req = 3'b010;
        tick();
        check("t4.grant", 32'(bus.grant), 32'b010);
        check("t4.start", 32'(bus.start), 32'd1);
        tick();
        check("t4.ack",   32'(bus.ack),   32'b010);
        check("t4.error", 32'(bus.error), 32'd1);
        bus.req = '0;
        tick();
        check("t4.error_off", 32'(bus.error), 32'd0);

        // 5: stall stuck high -> timeout in cycle 17, then a normal access
        bus.cs       = 10'b00_0100_0000;
        bus.ext_wait = 1'b1;
        bus.req      = 3'b100;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 1)  check("t5.grant", 32'(bus.grant), 32'b100);
            if (c == 16) check("t5.ack_c16", 32'(bus.ack), 32'd0);
        end
        check("t5.ack",   32'(bus.ack),   32'b100);
        check("t5.error", 32'(bus.error), 32'd1);
        bus.req      = '0;
        bus.ext_wait = 1'b0;
        tick();
        bus.req = 3'b001;
        tick();
        check("t5.next_grant", 32'(bus.grant), 32'b001);
        tick();
        tick();
        check("t5.next_ack",   32'(bus.ack),   32'b001);
        check("t5.next_error", 32'(bus.error), 32'd0);
        bus.req = '0;
        tick();

        // 6a: master 1 aborts in WAIT while master 2 waits its turn
        bus.ext_wait = 1'b1;
        bus.req      = 3'b110;
        tick();
        check("t6.grant1", 32'(bus.grant), 32'b010);
        tick();
        bus.req = 3'b100;
        tick();
        check("t6.abort_ack",   32'(bus.ack),   32'd0);
        check("t6.abort_busy",  32'(bus.busy),  32'd0);
        check("t6.abort_grant", 32'(bus.grant), 32'd0);
        bus.ext_wait = 1'b0;
        tick();
        check("t6.grant2", 32'(bus.grant), 32'b100);
        tick();
        tick();
        check("t6.ack2", 32'(bus.ack), 32'b100);
        bus.req = '0;
        tick();

        // 6b: reset during WAIT, then master 0 wins
        bus.ext_wait = 1'b1;
        bus.req      = 3'b010;
        tick();
        check("t6.rst_grant", 32'(bus.grant), 32'b010);
        tick();
        reset = 1'b1;
        tick();
        check_idle("t6.rst");
        reset        = 1'b0;
        bus.ext_wait = 1'b0;
        bus.req      = 3'b011;
        tick();
        check("t6.post_rst_grant", 32'(bus.grant), 32'b001);
        tick();
        tick();
        check("t6.post_rst_ack", 32'(bus.ack), 32'b001);
        bus.req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Round-robin arbiter and access sequencer for the shared system bus.
- Masters: 0 = CPU, 1 = VGA, 2 = DMA.
- Grants the bus to one requester at a time and generates the access start strobe. Applies per-slave programmable wait states from the decoded chipselect, honors slave stalls and times them out.
- Returns a one-cycle ack (with error flag) to the granted master.
- Sits between the masters and the address/data muxes and chipselect decoder. The muxes steer using `grant`.

## Interface
Parameters:
- NMASTER, 3, number of requesting masters.
- NCS, 10, number of chipselect lines from the decoder.
- TIMEOUT, 255, maximum `ext_wait` cycles tolerated before a bus error; must be ≥1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NMASTER  per-master request; held high until ack.
- cs  in  NCS  one-hot chipselect decoded from the currently granted address; all-zero means unmapped.
- ws_table  in  4*NCS  wait-state count for chipselect i in bits [4i+3:4i]; quasi-static.
- ext_wait  in  1  slave stall; sampled only after programmed wait states expire.
- grant  out  NMASTER  one-hot grant; all-zero when idle.
- start  out  1  one-cycle pulse in the first cycle of each access.
- ack  out  NMASTER  one-cycle completion pulse to the granted master.
- error  out  1  qualifies `ack`: high in the same cycle if the access was unmapped or timed out.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
States: IDLE, START, WAIT, DONE. All outputs are registered or decoded from state and grant.
- **IDLE**
  - If any `req` bit is set, select the first requester searching upward (with wrap) from `last+1`.
  - Register the one-hot grant and set `last` to the selected index. Go to START.
  - If no request, stay in IDLE.
- **START**
  - `start`=1.
  - If `cs`==0: set the error flag and go to DONE.
  - Otherwise load `wcnt` = `ws_table` field of the lowest-index set `cs` bit, clear `tcnt`, and go to WAIT.
- **WAIT**, evaluated in priority order:
  1. `req[g]`=0 (master aborted): clear grant, go to IDLE, no ack.
  2. `wcnt`≠0: decrement `wcnt`.
  3. `ext_wait`=1 and `tcnt`==TIMEOUT-1: set the error flag and go to DONE.
  4. `ext_wait`=1: increment `tcnt`.
  5. Otherwise: go to DONE.
- **DONE**
  - `ack[g]`=1 and `error` = error flag.
  - Clear grant and the error flag. Go to IDLE.
- Master contract: `req` must be low in the cycle after `ack`. A `req` that is high in IDLE is a new request.
- Arbitration is round-robin: a continuously requesting master cannot starve the others.
- `last` resets to NMASTER-1, so master 0 wins the first arbitration.
- More than one `cs` bit set is a decoder fault. The lowest index wins and no error is raised.
- `tcnt` width is $clog2(TIMEOUT). `wcnt` is 4 bits, so there are 0–15 programmed wait states.
- Reset values: state IDLE, `grant`=0, `start`=0, `ack`=0, `error`=0, `busy`=0, `wcnt`=0, `tcnt`=0, error flag=0, `last`=NMASTER-1.

## Timing
Cycle 0 is the IDLE cycle in which `req` is first sampled high.
- Cycle 1: `grant` valid, `start`=1, `busy`=1. `cs` must be valid in this cycle.
- Mapped access with W wait states and S `ext_wait` cycles (S < TIMEOUT): `ack` in cycle 3+W+S.
- Unmapped access: `ack`+`error` in cycle 2.
- Timeout with `ext_wait` held high: `ack`+`error` in cycle 2+W+TIMEOUT.
- After `ack` in cycle N, the earliest next grant is in cycle N+2 (IDLE at N+1). Bus turnaround is one idle cycle.
- Abort: `req` low in a WAIT cycle gives IDLE in the next cycle and no `ack` pulse.
- Reset asserted in any state: all outputs are 0 in the cycle after the reset edge. No `ack` is issued for an interrupted access.
- `ws_table` changes take effect only at the next START.

## Test plan
1. Master 0 only, `cs`=bit 6, ws=0, `ext_wait`=0 → `grant`=001 and `start` in cycle 1; `ack`=001, `error`=0 in cycle 3; `busy` low in cycle 4.
2. `cs`=bit 0 with ws=5, plus `ext_wait` high for 2 cycles after the wait states → `ack` in cycle 10, `error`=0.
3. All three `req` held continuously, ws=0 → grants in order 001, 010, 100, 001. Acks in cycles 3, 7, 11, 15.
4. `cs`=0 (unmapped) → `start` in cycle 1; `ack`+`error`=1 in cycle 2.
5. TIMEOUT=15, ws=0, `ext_wait` stuck high → `ack`+`error` in cycle 17; the next request is granted normally.
6. Master 1 drops `req` in a WAIT cycle while master 2 is requesting → no `ack[1]`; the arbiter returns to IDLE and grants master 2. Separately, assert `reset` in WAIT → all outputs 0 the next cycle, and master 0 wins the next arbitration.
